regfile_write_arbiter: RTL and testbench

//  Write-side front end of the 6-write-port CGRA register file. Buffers write requests from six

---
 rtl/cgra_rf_pkg.sv | 13 +
 rtl/rf_wr_fifo.sv | 65 ++++++
 rtl/regfile_write_arbiter.sv | 127 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_rf_pkg.sv
// rtl/cgra_rf_pkg.sv - shared constants and write-request type for the CGRA register-file write path
package cgra_rf_pkg;

  localparam int LOG2REGS = 3;
  localparam int SIZE     = 32;
  localparam int NPORTS   = 6;

  typedef struct packed {
    logic [LOG2REGS-1:0] addr;
    logic [SIZE-1:0]     data;
  } wr_req_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// rtl/rf_wr_fifo.sv - per-port synchronous FIFO of register-file write requests
module rf_wr_fifo import cgra_rf_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  wr_req_t push_req,
  output wr_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  wr_req_t       mem_q [DEPTH];
  wr_req_t       mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_req;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - buffers six write producers and issues address-conflict-free
// register-file write lanes under round-robin priority
module regfile_write_arbiter #(
  parameter int NPORTS   = cgra_rf_pkg::NPORTS,
  parameter int log2regs = cgra_rf_pkg::LOG2REGS,
  parameter int size     = cgra_rf_pkg::SIZE,
  parameter int DEPTH    = 2
) (
  input  logic                       CGRA_Clock,
  input  logic                       CGRA_Reset,
  input  logic [NPORTS-1:0]          req_valid,
  output logic [NPORTS-1:0]          req_ready,
  input  logic [NPORTS*log2regs-1:0] req_addr,
  input  logic [NPORTS*size-1:0]     req_data,
  output logic [NPORTS-1:0]          WE,
  output logic [NPORTS*log2regs-1:0] address_in,
  output logic [NPORTS*size-1:0]     data_in,
  output logic                       busy,
  output logic [15:0]                conflict_cnt
);
  import cgra_rf_pkg::*;

  localparam int PW    = $clog2(NPORTS);
  localparam int NREGS = 2 ** log2regs;

  wr_req_t                    push_req [NPORTS];
  wr_req_t                    head     [NPORTS];
  logic [NPORTS-1:0]          full, empty, push, win;
  logic                       loser;
  logic [NREGS-1:0]           taken;
  logic [PW:0]                p_wide;
  logic [PW-1:0]              idx;
  logic [PW-1:0]              rr_ptr_q, rr_ptr_d;
  logic                       ready_en_q, ready_en_d;
  logic [NPORTS-1:0]          we_q, we_d;
  logic [NPORTS*log2regs-1:0] addr_q, addr_d;
  logic [NPORTS*size-1:0]     data_q, data_d;
  logic [15:0]                cnt_q, cnt_d;

  // ready_en_q keeps every port closed during reset and for the edge that releases it
  assign req_ready    = ready_en_q ? ~full : '0;
  assign push         = req_valid & req_ready;
  assign WE           = we_q;
  assign address_in   = addr_q;
  assign data_in      = data_q;
  assign conflict_cnt = cnt_q;
  assign busy         = (~&empty) | (|we_q);

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    assign push_req[i] = {req_addr[i*log2regs +: log2regs], req_data[i*size +: size]};

    rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (CGRA_Clock),
      .rst_n    (CGRA_Reset),
      .push     (push[i]),
      .pop      (win[i]),
      .push_req (push_req[i]),
      .head     (head[i]),
      .full     (full[i]),
      .empty    (empty[i])
    );
  end

  // One pass from rr_ptr; the first head to claim an address owns it this cycle
  always_comb begin
    win    = '0;
    taken  = '0;
    loser  = 1'b0;
    p_wide = '0;
    idx    = '0;
    for (int k = 0; k < NPORTS; k++) begin
      p_wide = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (p_wide >= (PW+1)'(NPORTS)) begin
        p_wide = p_wide - (PW+1)'(NPORTS);
      end
      idx = p_wide[PW-1:0];
      if (!empty[idx]) begin
        if (taken[head[idx].addr]) begin
          loser = 1'b1;
        end else begin
          win[idx]               = 1'b1;
          taken[head[idx].addr] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ready_en_d = 1'b1;
    we_d       = win;
    addr_d     = addr_q;
    data_d     = data_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    for (int i = 0; i < NPORTS; i++) begin
      if (win[i]) begin
        addr_d[i*log2regs +: log2regs] = head[i].addr;
        data_d[i*size +: size]         = head[i].data;
      end
    end
    if (loser) begin
      rr_ptr_d = (rr_ptr_q == PW'(NPORTS-1)) ? '0 : rr_ptr_q + 1'b1;
      if (cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CGRA_Clock or negedge CGRA_Reset) begin
    if (!CGRA_Reset) begin
      ready_en_q <= 1'b0;
      we_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      ready_en_q <= ready_en_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [5:0]   req_valid = '0;
  logic [5:0]   req_ready;
  logic [17:0]  req_addr = '0;
  logic [191:0] req_data = '0;
  logic [5:0]   WE;
  logic [17:0]  address_in;
  logic [191:0] data_in;
  logic         busy;
  logic [15:0]  conflict_cnt;

  int total = 0;
  int bad   = 0;

  logic [34:0] sbq [6][$];
  int          wait_c [6];
  logic [31:0] rf [8];

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .CGRA_Clock   (clk),
    .CGRA_Reset   (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .WE           (WE),
    .address_in   (address_in),
    .data_in      (data_in),
    .busy         (busy),
    .conflict_cnt (conflict_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: accepted requests queue per port; every WE lane must match its port's oldest entry
  always @(negedge clk) begin
    logic dup;
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) begin
        sbq[i].delete();
        wait_c[i] = 0;
      end
    end else begin
      dup = 1'b0;
      for (int i = 0; i < 6; i++) begin
        for (int j = 0; j < i; j++) begin
          if (WE[i] && WE[j] && address_in[i*3 +: 3] == address_in[j*3 +: 3]) dup = 1'b1;
        end
      end
      if (WE != 6'h00) chk("dup_addr", 64'(dup), 64'd0);
      for (int i = 0; i < 6; i++) begin
        if (WE[i]) begin
          if (sbq[i].size() == 0) begin
            chk("stale_we", 64'(i), 64'd99);
          end else begin
            chk("commit", 64'({address_in[i*3 +: 3], data_in[i*32 +: 32]}), 64'(sbq[i].pop_front()));
            chk("wait", 64'(wait_c[i] <= 6), 64'd1);
          end
          rf[address_in[i*3 +: 3]] = data_in[i*32 +: 32];
          wait_c[i] = 0;
        end else if (sbq[i].size() != 0) begin
          wait_c[i]++;
        end
      end
      for (int i = 0; i < 6; i++) begin
        if (req_valid[i] && req_ready[i]) sbq[i].push_back({req_addr[i*3 +: 3], req_data[i*32 +: 32]});
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] mask);
    logic [5:0] acc;
    req_valid = mask;
    for (int c = 0; c < 20 && req_valid != 6'h00; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1 req_valid = req_valid & ~acc;
    end
    chk("send_timeout", 64'(req_valid), 64'd0);
    req_valid = '0;
  endtask

  task automatic run(input logic [5:0] mask, input bit rnd, input int ncyc);
    logic [5:0] acc, held;
    req_valid = mask;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) begin
        if (acc[i]) begin
          req_data[i*32 +: 32] = $urandom;
          if (rnd) req_addr[i*3 +: 3] = 3'($urandom_range(0, 7));
        end
      end
      if (rnd) begin
        held = req_valid & ~acc;
        req_valid = held | (mask & ~held & 6'($urandom));
      end
    end
  endtask

  task automatic drain();
    int left;
    req_valid = '0;
    left = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      left = 0;
      for (int i = 0; i < 6; i++) left += sbq[i].size();
      if (left == 0 && !busy) break;
    end
    chk("drain_q", 64'(left), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int n2;
    int chk_next;
    logic [5:0] acc;

    // Reset with random request noise
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 req_valid = 6'($urandom);
      chk("rst_ready", 64'(req_ready), 64'd0);
    end
    chk("rst_we", 64'(WE), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt", 64'(conflict_cnt), 64'd0);
    @(posedge clk);
    #1 req_valid = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rel_ready", 64'(req_ready), 64'h3F);

    // All six ports, distinct addresses
    for (int i = 0; i < 6; i++) begin
      req_addr[i*3 +: 3]   = 3'(i);
      req_data[i*32 +: 32] = 32'hA0 + 32'(i);
    end
    send(6'h3F);
    @(negedge clk) chk("nc_e0_we", 64'(WE), 64'd0);
    @(negedge clk) chk("nc_e1_we", 64'(WE), 64'h3F);
    chk("nc_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 6; i++) begin
      chk("nc_addr", 64'(address_in[i*3 +: 3]), 64'(i));
      chk("nc_data", 64'(data_in[i*32 +: 32]), 64'hA0 + 64'(i));
    end
    @(negedge clk) chk("nc_e2_we", 64'(WE), 64'd0);
    chk("nc_cnt", 64'(conflict_cnt), 64'd0);

    // Ports 1 and 4 collide on address 5 with rr_ptr at 0
    @(posedge clk);
    #1 req_addr[3 +: 3] = 3'd5;
    req_data[32 +: 32]  = 32'd11;
    req_addr[12 +: 3]   = 3'd5;
    req_data[128 +: 32] = 32'd44;
    send(6'h12);
    @(negedge clk) chk("sa_e0_we", 64'(WE), 64'd0);
    @(negedge clk) chk("sa_e1_we", 64'(WE), 64'h02);
    chk("sa_e1_data", 64'(data_in[32 +: 32]), 64'd11);
    @(negedge clk) chk("sa_e2_we", 64'(WE), 64'h10);
    chk("sa_e2_data", 64'(data_in[128 +: 32]), 64'd44);
    @(posedge clk);
    #1 chk("sa_rf5", 64'(rf[5]), 64'd44);
    chk("sa_cnt", 64'(conflict_cnt), 64'd1);

    // Port 2 backpressured by a constant port-0 stream on the same address
    do_reset();
    req_addr[0 +: 3]  = 3'd3;
    req_addr[6 +: 3]  = 3'd3;
    req_data[0 +: 32] = 32'h1000;
    req_data[64 +: 32] = 32'h2000;
    req_valid = 6'h05;
    n2 = 0;
    chk_next = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (chk_next == 1) begin
        chk("full_after2", 64'(req_ready[2]), 64'd0);
        chk_next = 2;
      end
      if (acc[2]) n2++;
      if (n2 == 2 && chk_next == 0) chk_next = 1;
      @(posedge clk);
      #1;
      if (acc[0]) req_data[0 +: 32] = req_data[0 +: 32] + 32'd1;
      if (acc[2]) req_data[64 +: 32] = req_data[64 +: 32] + 32'd1;
      if (n2 == 3) req_valid[2] = 1'b0;
      if (n2 == 3 && sbq[2].size() == 0) break;
    end
    chk("bp_accepts", 64'(n2), 64'd3);
    chk("bp_full_seen", 64'(chk_next), 64'd2);
    chk("bp_p2_done", 64'(sbq[2].size()), 64'd0);
    drain();

    // Random mixed traffic
    run(6'h3F, 1'b1, 400);
    drain();

    // Reset with four FIFOs holding colliding writes
    for (int i = 0; i < 4; i++) req_addr[i*3 +: 3] = 3'd7;
    run(6'h0F, 1'b0, 3);
    chk("mid_busy_pre", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("mid_we", 64'(WE), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_ready", 64'(req_ready), 64'd0);
    chk("mid_cnt", 64'(conflict_cnt), 64'd0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk) chk("mid_no_stale", 64'(WE), 64'd0);
    end
    chk("mid_ready_rel", 64'(req_ready), 64'h3F);

    // Two ports fighting over address 0 every cycle until the counter saturates
    @(posedge clk);
    #1 req_addr[0 +: 3] = 3'd0;
    req_addr[3 +: 3] = 3'd0;
    run(6'h03, 1'b0, 1000);
    chk("sat_cnt_1000", 64'(conflict_cnt), 64'd999);
    run(6'h03, 1'b0, 65000);
    chk("sat_cnt", 64'(conflict_cnt), 64'hFFFF);
    run(6'h03, 1'b0, 20);
    chk("sat_hold", 64'(conflict_cnt), 64'hFFFF);
    drain();
    chk("sat_hold_idle", 64'(conflict_cnt), 64'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
